// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer: strips MII preamble/SFD, assembles bytes low nibble first, checks FCS/length
// and emits a framed byte stream with a per-frame status word.
module mii_rx_deframer #(
   parameter int MIN_FRAME_BYTES = 64,
   parameter int MAX_FRAME_BYTES = 1522
) (
   input  logic        rx_clk,
   input  logic        reset,
   input  logic        rx_dv,
   input  logic [3:0]  rxd,
   input  logic        rx_er,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sof,
   output logic        out_eof,
   output logic [4:0]  out_status,
   output logic        out_good,
   output logic [15:0] frame_ok_count,
   output logic [15:0] frame_err_count
);
   localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
   localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
   state_t state, state_nx;
   logic dv1, dv2, er1;
   logic [3:0] d1, lo;
   logic phase, held, sent, er_seen;
   logic [31:0] crc, crc_b, crc_nx;
   logic [15:0] cnt;
   logic [7:0] hold, e_data;
   logic fin, giant, take, em_valid, em_eof;
   logic [4:0] em_status, e_status;
   logic e_valid, e_sof, e_eof, e_empty;

   function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 4; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
      return r;
   endfunction

   assign crc_nx = crc_nibble(crc, d1);

   always_ff @(posedge rx_clk)
      state <= reset ? IDLE : state_nx;

   always_comb begin
      state_nx = state;
      fin = 1'b0;
      giant = 1'b0;
      take = 1'b0;
      case (state)
         IDLE:     if (dv1 && !dv2) state_nx = d1 == 4'h5 ? PREAMBLE : d1 == 4'hD ? DATA : DROP;
         PREAMBLE: state_nx = !dv1 ? IDLE : er1 ? DROP : d1 == 4'h5 ? PREAMBLE : d1 == 4'hD ? DATA : DROP;
         DATA: begin
            fin = !dv1;
            giant = dv1 && phase && cnt == MAX_LEN;
            take = dv1 && phase && cnt != MAX_LEN;
            state_nx = fin ? IDLE : giant ? DROP : DATA;
         end
         default:  state_nx = dv1 ? DROP : IDLE;
      endcase
      // the held byte goes out when a newer byte arrives, or as the last byte at end/truncation
      em_eof = giant || (fin && cnt != '0);
      em_valid = em_eof || (take && held);
      em_status = em_eof ? {giant, fin && phase, fin && cnt < MIN_LEN, er_seen, crc_b != CRC_RESIDUE} : 5'd0;
   end

   always_ff @(posedge rx_clk) begin
      if (reset) begin
         {dv1, dv2, er1, d1} <= '0;
         {phase, held, sent, er_seen, lo, cnt, hold} <= '0;
         crc <= '1;
         crc_b <= '1;
         {e_valid, e_sof, e_eof, e_empty, e_data, e_status} <= '0;
         {out_valid, out_sof, out_eof, out_good, out_data, out_status} <= '0;
         frame_ok_count <= '0;
         frame_err_count <= '0;
      end else begin
         dv1 <= rx_dv;
         d1 <= rxd;
         er1 <= rx_er;
         dv2 <= dv1;
         if (state != DATA) begin
            {phase, held, sent, er_seen, cnt} <= '0;
            crc <= '1;
            crc_b <= '1;
         end else if (dv1) begin
            phase <= ~phase;
            crc <= crc_nx;
            er_seen <= er_seen || er1;
            if (!phase) lo <= d1;
            if (take) {hold, held, cnt, crc_b} <= {d1, lo, 1'b1, cnt + 16'd1, crc_nx};
            if (em_valid) sent <= 1'b1;
         end
         e_valid <= em_valid;
         e_data <= hold;
         e_sof <= em_valid && !sent;
         e_eof <= em_eof;
         e_status <= em_status;
         e_empty <= fin && cnt == '0;
         out_valid <= e_valid;
         out_data <= e_data;
         out_sof <= e_sof;
         out_eof <= e_eof;
         out_status <= e_status;
         out_good <= e_valid && e_eof && e_status == 5'd0;
         frame_ok_count <= frame_ok_count + 16'(e_valid && e_eof && e_status == 5'd0);
         frame_err_count <= frame_err_count + 16'(e_empty || (e_valid && e_eof && e_status != 5'd0));
      end
   end
endmodule

// File: tb/tb_mii_rx_deframer.sv
// tb_mii_rx_deframer: drives nibble-level frames and checks every output cycle against a
// frame-level model that schedules expected beats and counter bumps.
module tb_mii_rx_deframer;
   localparam int MIN = 64;
   localparam int MAX = 1522;
   localparam logic [31:0] RES = 32'hDEBB20E3;

   logic rx_clk = 1'b0, reset = 1'b1, rx_dv = 1'b0, rx_er = 1'b0;
   logic [3:0] rxd = 4'h0;
   logic out_valid, out_sof, out_eof, out_good;
   logic [7:0] out_data;
   logic [4:0] out_status;
   logic [15:0] frame_ok_count, frame_err_count;

   typedef struct {
      int cyc;
      bit beat;
      bit empty;
      logic [7:0] data;
      bit sof;
      bit eof;
      logic [4:0] st;
   } ev_t;

   ev_t exp_q[$];
   logic [7:0] frm[$];
   logic [4:0] st_log[$];
   int cyc = 0, checks = 0, errors = 0, ok_m = 0, err_m = 0;
   int dut_beats = 0, last_dut_beats = 0;

   mii_rx_deframer #(.MIN_FRAME_BYTES(MIN), .MAX_FRAME_BYTES(MAX)) dut (
      .rx_clk(rx_clk), .reset(reset), .rx_dv(rx_dv), .rxd(rxd), .rx_er(rx_er),
      .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
      .out_status(out_status), .out_good(out_good),
      .frame_ok_count(frame_ok_count), .frame_err_count(frame_err_count)
   );

   always #20 rx_clk = ~rx_clk;
   always @(posedge rx_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reflected CRC register over whole bytes, no final inversion
   function automatic logic [31:0] crc_reg(input logic [7:0] b[$], input int len);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < len; k++) begin
         c ^= {24'h0, b[k]};
         for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
      end
      return c;
   endfunction

   task automatic build(input int len, input bit good);
      logic [31:0] fcs;
      frm.delete();
      for (int k = 0; k < len; k++) frm.push_back(8'($urandom));
      if (good && len >= 4) begin
         fcs = ~crc_reg(frm, len - 4);
         for (int i = 0; i < 4; i++) frm[len - 4 + i] = fcs[8*i +: 8];
      end
   endtask

   task automatic drive(input bit dv, input logic [3:0] d, input bit er);
      @(negedge rx_clk);
      rx_dv = dv;
      rxd = d;
      rx_er = er;
   endtask

   // pins sampled at the next edge; output appears two edges later
   task automatic push_beat(input logic [7:0] d, input bit sof, input bit eof, input logic [4:0] st);
      exp_q.push_back('{cyc: cyc + 3, beat: 1'b1, empty: 1'b0, data: d, sof: sof, eof: eof, st: st});
   endtask

   task automatic send_frame(input int npre, input bit dribble, input int er_byte, input int gap, input int abort);
      int n, lim;
      bit ers, bad;
      n = frm.size();
      lim = n > MAX ? MAX : n;
      ers = er_byte >= 0 && er_byte < lim;
      bad = crc_reg(frm, lim) != RES;
      repeat (npre) drive(1'b1, 4'h5, 1'b0);
      drive(1'b1, 4'hD, 1'b0);
      for (int k = 0; k < n; k++) begin
         if (k == abort) begin
            drive(1'b1, 4'h0, 1'b0);
            reset = 1'b1;
            exp_q.delete();
            ok_m = 0;
            err_m = 0;
            repeat (2) drive(1'b1, 4'h0, 1'b0);
            reset = 1'b0;
            repeat (4) drive(1'b1, 4'h0, 1'b0);
            repeat (gap) drive(1'b0, 4'h0, 1'b0);
            return;
         end
         drive(1'b1, frm[k][3:0], k == er_byte);
         drive(1'b1, frm[k][7:4], 1'b0);
         if (k >= 1 && k < lim) push_beat(frm[k-1], k == 1, 1'b0, 5'd0);
         if (k == lim) push_beat(frm[k-1], k == 1, 1'b1, {1'b1, 1'b0, 1'b0, ers, bad});
      end
      if (dribble) drive(1'b1, 4'($urandom), 1'b0);
      drive(1'b0, 4'($urandom), 1'b0);
      if (n == 0) exp_q.push_back('{cyc: cyc + 3, beat: 1'b0, empty: 1'b1, data: 8'h0, sof: 1'b0, eof: 1'b0, st: 5'd0});
      else if (n <= MAX) push_beat(frm[n-1], n == 1, 1'b1, {1'b0, dribble, n < MIN, ers, bad});
      repeat (gap - 1) drive(1'b0, 4'($urandom), 1'b0);
   endtask

   initial forever begin
      ev_t e;
      @(posedge rx_clk);
      #1;
      e = '{cyc: 0, beat: 1'b0, empty: 1'b0, data: 8'h0, sof: 1'b0, eof: 1'b0, st: 5'd0};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         chk("missed_event_cycle", exp_q[0].cyc, cyc);
         exp_q.delete(0);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q[0];
         exp_q.delete(0);
      end
      if (e.empty || (e.beat && e.eof && e.st != 5'd0)) err_m++;
      if (e.beat && e.eof && e.st == 5'd0) ok_m++;
      if (e.beat && e.eof) st_log.push_back(e.st);
      if (reset) begin
         chk("reset_data", out_data, 0);
         chk("reset_status", out_status, 0);
         chk("reset_sof", out_sof, 0);
         chk("reset_eof", out_eof, 0);
      end
      chk("out_valid", out_valid, e.beat);
      chk("out_good", out_good, e.beat && e.eof && e.st == 5'd0);
      if (e.beat) begin
         chk("out_data", out_data, e.data);
         chk("out_sof", out_sof, e.sof);
         chk("out_eof", out_eof, e.eof);
         if (e.eof) chk("out_status", out_status, e.st);
      end
      chk("frame_ok_count", frame_ok_count, 16'(ok_m));
      chk("frame_err_count", frame_err_count, 16'(err_m));
      if (out_valid) begin
         dut_beats++;
         if (out_eof) begin
            last_dut_beats = dut_beats;
            dut_beats = 0;
         end
      end
      if (reset) dut_beats = 0;
   end

   initial begin
      #8000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] s[$];
      logic [7:0] g1[$];
      int len, er, npre, gap;
      bit good, drib;
      for (int i = 0; i < 9; i++) s.push_back(8'h31 + 8'(i));
      chk("crc_model_123456789", ~crc_reg(s, 9), 32'hCBF43926);
      repeat (3) drive(1'b0, 4'h0, 1'b0);
      reset = 1'b0;
      repeat (4) drive(1'b0, 4'h0, 1'b0);
      chk("reset_ok_count", frame_ok_count, 0);
      // good 64-byte frame with a full 7x55 + D5 preamble
      build(64, 1'b1);
      g1 = frm;
      st_log.delete();
      send_frame(15, 1'b0, -1, 4, -1);
      chk("good_beats", last_dut_beats, 64);
      chk("good_status", st_log[0], 5'b00000);
      chk("good_ok_count", frame_ok_count, 1);
      // single bit error in byte 10
      frm = g1;
      frm[9] ^= 8'h04;
      st_log.delete();
      send_frame(15, 1'b0, -1, 4, -1);
      chk("crc_beats", last_dut_beats, 64);
      chk("crc_status", st_log[0], 5'b00001);
      chk("crc_err_count", frame_err_count, 1);
      // runt followed back-to-back by a dribble frame with rx_er at byte 30
      st_log.delete();
      build(20, 1'b1);
      send_frame(15, 1'b0, -1, 1, -1);
      build(64, 1'b1);
      send_frame(15, 1'b1, 30, 4, -1);
      chk("runt_status", st_log[0], 5'b00100);
      chk("dribble_er_status", st_log[1], 5'b01010);
      chk("two_frames_err_count", frame_err_count, 3);
      // giant then a good frame
      st_log.delete();
      build(1600, 1'b0);
      send_frame(15, 1'b0, -1, 4, -1);
      chk("giant_beats", last_dut_beats, 1522);
      chk("giant_bit", st_log[0][4], 1);
      build(64, 1'b1);
      send_frame(15, 1'b0, -1, 4, -1);
      chk("after_giant_status", st_log[1], 5'b00000);
      chk("after_giant_ok_count", frame_ok_count, 2);
      // bad preamble nibble, then SFD straight into end of frame
      repeat (5) drive(1'b1, 4'h5, 1'b0);
      drive(1'b1, 4'h7, 1'b0);
      repeat (3) drive(1'b1, 4'h5, 1'b0);
      repeat (4) drive(1'b0, 4'h0, 1'b0);
      chk("bad_pre_ok_count", frame_ok_count, 2);
      chk("bad_pre_err_count", frame_err_count, 4);
      frm.delete();
      send_frame(7, 1'b0, -1, 4, -1);
      chk("empty_err_count", frame_err_count, 5);
      // length boundaries
      build(63, 1'b1);
      send_frame(3, 1'b0, -1, 2, -1);
      build(1522, 1'b1);
      send_frame(0, 1'b0, -1, 2, -1);
      build(1523, 1'b1);
      send_frame(1, 1'b0, -1, 2, -1);
      build(1, 1'b0);
      send_frame(2, 1'b0, -1, 3, -1);
      // reset mid-frame with rx_dv held high
      build(100, 1'b1);
      send_frame(15, 1'b0, -1, 4, 40);
      chk("post_reset_ok_count", frame_ok_count, 0);
      chk("post_reset_err_count", frame_err_count, 0);
      build(64, 1'b1);
      send_frame(15, 1'b0, -1, 4, -1);
      chk("after_reset_ok_count", frame_ok_count, 1);
      for (int f = 0; f < 60; f++) begin
         len = $urandom_range(0, 90);
         good = 1'($urandom_range(0, 1));
         drib = $urandom_range(0, 3) == 0;
         er = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 90)) : -1;
         npre = $urandom_range(0, 15);
         gap = $urandom_range(1, 4);
         build(len, good);
         send_frame(npre, drib, er, gap, -1);
      end
      repeat (6) drive(1'b0, 4'h0, 1'b0);
      chk("all_events_seen", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mii_rx_deframer.md
# mii_rx_deframer

Receive-side MII deframer on the rx_clk domain. Takes raw nibbles from a 100baseTX PHY's MII receive pins, strips preamble and SFD, and assembles bytes low nibble first. It checks the Ethernet FCS, byte count and error conditions, then emits a byte stream with start/end markers and a per-frame status word. It feeds frame consumers (packet FIFOs, capture logic) that need byte-aligned, validated frames rather than raw nibbles.

## Interface
- MIN_FRAME_BYTES, 64, minimum legal frame length in bytes, including FCS
- MAX_FRAME_BYTES, 1522, maximum legal frame length in bytes, including FCS; must be ≤ 65535
- rx_clk  input  1  MII receive clock, 25 MHz
- reset  input  1  reset, synchronous, active-high
- rx_dv  input  1  MII receive data valid
- rxd  input  4  MII receive nibble
- rx_er  input  1  MII receive error
- out_valid  output  1  out_data holds a frame byte this cycle
- out_data  output  8  frame byte, {high nibble, low nibble}; FCS bytes included
- out_sof  output  1  first byte of frame; qualified by out_valid
- out_eof  output  1  last byte of frame; qualified by out_valid
- out_status  output  5  valid with out_eof: [0] crc_err, [1] rx_er_seen, [2] runt, [3] dribble, [4] giant
- out_good  output  1  out_valid && out_eof && out_status == 0
- frame_ok_count  output  16  frames ending with status 0; wraps
- frame_err_count  output  16  frames ending with nonzero status, plus empty frames (SFD then end); wraps

## Operation
- Input stage: rx_dv, rxd, rx_er registered into s1. rx_dv is also registered into s2. All decisions use s1.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: a rising edge (rx_dv_s1 && !rx_dv_s2) evaluates the s1 nibble:
  - 0x5 → PREAMBLE
  - 0xD → DATA (short preamble accepted)
  - anything else → DROP
  - Without a rising edge, stay in IDLE. A frame in progress at reset release is therefore ignored.
- PREAMBLE, with rx_dv_s1 high:
  - 0x5 → stay
  - 0xD → DATA
  - any other nibble, or rx_er_s1 → DROP
- PREAMBLE, rx_dv_s1 low → IDLE. No output, no counter change.
- DROP: stay until rx_dv_s1 is low, then IDLE.
- DATA:
  - Nibble phase toggles, starting at low.
  - Low nibble is latched.
  - High nibble completes a byte. CRC32 is updated per nibble: reflected, poly 0xEDB88320, init 0xFFFFFFFF, LSB-first.
  - rx_er_s1 while in DATA sets rx_er_seen.
- Byte holding: each completed byte is placed in a one-byte hold register. The previously held byte is emitted at the same time, so out_eof always rides on the true last byte.
- End of frame: rx_dv_s1 low while in DATA.
  - Emit the held byte with out_eof=1 and the status bits below, then go to IDLE.
  - crc_err: CRC register ≠ 0xDEBB20E3.
  - runt: byte count < MIN_FRAME_BYTES.
  - dribble: a low nibble was pending; it is discarded.
  - If zero bytes were received, emit nothing and increment frame_err_count.
- Giant: a completed byte that would be byte number MAX_FRAME_BYTES+1 truncates the frame.
  - The held byte (byte MAX) is emitted with out_eof and status[4]=1, along with any other applicable bits (crc_err is evaluated at that point).
  - Then go to DROP; the overflowing byte is discarded.
- Counters:
  - The byte counter is 16 bits and never exceeds MAX_FRAME_BYTES.
  - frame_ok_count and frame_err_count increment in the same cycle as out_eof (or the empty-frame end) and wrap at 0xFFFF→0.

## Timing
- Reset values: out_valid, out_sof, out_eof, out_good = 0; out_data, out_status = 0; both counters 0; state IDLE; s1/s2 = 0.
- All outputs are registered.
- out_valid is a one-cycle pulse per byte. Beats are spaced at least 2 cycles apart. There is no backpressure.
- Byte k (k < last) is emitted 3 rx_clk edges after the high nibble of byte k+1 is on the pins: 1 edge into s1, 1 edge to process, 1 edge to the output register.
- The last byte is emitted 3 edges after rx_dv is first sampled low on the pins.
- out_sof is asserted on the first emitted byte. For a 1-byte frame, out_sof and out_eof are both 1 on the same beat.
- Back-to-back frames with a single rx_dv-low cycle between them: the first frame's eof is emitted, and the next rising edge is detected normally. No frame loss.
- Reset mid-frame: outputs clear on the next edge. No eof is emitted for the aborted frame, and no counter change occurs after reset.

## Test plan
- Good frame: 7×0x55, 0xD5, then 60 data bytes + correct FCS → 64 beats; sof on beat 1, eof on beat 64, out_status=0, out_good=1, frame_ok_count=1.
- Same frame with 1 bit flipped in byte 10 → 64 beats, out_status=5'b00001, out_good=0, frame_err_count=1.
- Two frames: a 20-byte frame with correct FCS → status 5'b00100. A 64-byte frame with an extra trailing nibble and rx_er pulsed at byte 30 → status has bits [3] and [1] set; bit [0] is set only if the FCS check fails on the stored bytes.
- Giant: 1600 bytes → eof on beat 1522 with status[4]=1. No further beats until rx_dv is low. A following good 64-byte frame yields out_good=1.
- Preamble nibble 0x7 mid-preamble → no beats, counters unchanged. SFD immediately followed by rx_dv low → no beats, frame_err_count +1.
- Reset asserted for 2 cycles at byte 40 with rx_dv held high → all outputs 0, no eof for the aborted frame. The next frame after rx_dv low is received correctly with frame_ok_count=1.
